// File: rtl/regfile_stack_pkg.sv
// regfile_stack_pkg
//   Shared constants and types for the register file / return-address stack.
//   DEF_* : default widths and depths used as parameter defaults.
//   stack_op_e : decoded push/pop request for the return stack.
package regfile_stack_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_REGS    = 8;
    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_SWAP = 2'd3
    } stack_op_e;

endpackage

// File: rtl/ret_stack.sv
// ret_stack
//   Hardware return-address LIFO used for CALL/RET.
//   Ports:
//     clk, reset          clock (rising edge), asynchronous active-high reset
//     push, push_pc       CALL: store push_pc+1 on top of stack
//     pop                 RET: pop the top entry into pop_pc
//     clr_err             clears the sticky error flags
//     pop_pc, pop_valid   registered return address and its 1-cycle strobe
//     stack_full/empty    combinational from the stack pointer
//     stack_ovf/unf       sticky overflow / underflow flags
module ret_stack
    import regfile_stack_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic            pop,
    input  logic            clr_err,
    output logic [PC_W-1:0] pop_pc,
    output logic            pop_valid,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_ovf,
    output logic            stack_unf
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  sp;
    logic [PC_W-1:0]  mem [STACK_DEPTH];
    stack_op_e        op;

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [PC_W-1:0]  ret_addr;
    logic             wr_en;
    logic             rd_en;
    logic             sp_inc;
    logic             sp_dec;
    logic             set_ovf;
    logic             set_unf;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // When sp == STACK_DEPTH the low bits wrap to 0, so top_idx still lands
    // on the last entry; free_idx is only used when the stack is not full.
    assign free_idx = sp[IDX_W-1:0];
    assign top_idx  = free_idx - IDX_W'(1);
    assign ret_addr = push_pc + PC_W'(1);

    always_comb begin
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_SWAP;
            default: op = OP_NONE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = free_idx;
        rd_en   = 1'b0;
        sp_inc  = 1'b0;
        sp_dec  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (op)
            OP_PUSH: begin
                if (stack_full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    sp_inc = 1'b1;
                end
            end
            OP_POP: begin
                if (stack_empty) begin
                    set_unf = 1'b1;
                end else begin
                    rd_en  = 1'b1;
                    sp_dec = 1'b1;
                end
            end
            OP_SWAP: begin
                if (stack_empty) begin
                    // Failed pop, but the push half still goes through.
                    set_unf = 1'b1;
                    wr_en   = 1'b1;
                    sp_inc  = 1'b1;
                end else begin
                    // Old top is read out and overwritten in the same edge.
                    rd_en  = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp        <= '0;
            pop_pc    <= '0;
            pop_valid <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (sp_inc) begin
                sp <= sp + SP_W'(1);
            end else if (sp_dec) begin
                sp <= sp - SP_W'(1);
            end
            if (wr_en) begin
                mem[wr_idx] <= ret_addr;
            end
            if (rd_en) begin
                pop_pc <= mem[top_idx];
            end
            pop_valid <= rd_en;
            // A fresh error in the clearing cycle keeps the flag set.
            stack_ovf <= set_ovf | (stack_ovf & ~clr_err);
            stack_unf <= set_unf | (stack_unf & ~clr_err);
        end
    end

endmodule

// File: rtl/regfile_stack.sv
// regfile_stack
//   2-read / 1-write general-purpose register file with an independent
//   return-address stack (ret_stack) for CALL/RET.
//   Ports:
//     clk, reset             clock (rising edge), asynchronous active-high reset
//     rs1, rs2 -> rd1, rd2   combinational read ports
//     regwrite, ws, wd       synchronous write port
//     push, push_pc, pop     return-stack requests from the control unit
//     pop_pc, pop_valid      return address to fetch, 1-cycle strobe
//     stack_full/empty/ovf/unf, clr_err   stack status and error clear
//   Build option: define REGFILE_BYPASS_EN to forward wd to a read port whose
//   index matches ws while regwrite is high; otherwise reads show stored data.
module regfile_stack
    import regfile_stack_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int ADDR_W      = $clog2(NUM_REGS),
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] ws,
    input  logic [DATA_W-1:0] wd,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              pop,
    output logic [PC_W-1:0]   pop_pc,
    output logic              pop_valid,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_ovf,
    output logic              stack_unf,
    input  logic              clr_err
);

    logic [DATA_W-1:0] gpr [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (regwrite) begin
            gpr[ws] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd1 = (regwrite && (ws == rs1)) ? wd : gpr[rs1];
    assign rd2 = (regwrite && (ws == rs2)) ? wd : gpr[rs2];
`else
    assign rd1 = gpr[rs1];
    assign rd2 = gpr[rs2];
`endif

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_pc     (push_pc),
        .pop         (pop),
        .clr_err     (clr_err),
        .pop_pc      (pop_pc),
        .pop_valid   (pop_valid),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

endmodule

// File: tb/tb_regfile_stack.sv
// tb_regfile_stack
//   Directed bench for regfile_stack. Expected return addresses are queued as
//   pops are issued; a monitor pops and compares on every pop_valid strobe.
//   Register reads and stack flags are compared directly against constants.
module tb_regfile_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rs1, rs2, ws;
    logic [31:0] rd1, rd2, wd;
    logic        regwrite;
    logic        push, pop, clr_err;
    logic [7:0]  push_pc, pop_pc;
    logic        pop_valid, stack_full, stack_empty, stack_ovf, stack_unf;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    regfile_stack dut (
        .clk         (clk),
        .reset       (reset),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd1         (rd1),
        .rd2         (rd2),
        .regwrite    (regwrite),
        .ws          (ws),
        .wd          (wd),
        .push        (push),
        .push_pc     (push_pc),
        .pop         (pop),
        .pop_pc      (pop_pc),
        .pop_valid   (pop_valid),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    // Monitor: every pop_valid strobe must match the oldest expected address.
    always @(negedge clk) begin
        if (!reset && pop_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got pop_pc=%h with no pop pending", pop_pc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (pop_pc !== e) begin
                    n_err++;
                    $display("FAIL pop_pc: got %h expected %h", pop_pc, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] pc);
        push    = 1'b1;
        push_pc = pc;
        cyc();
        push    = 1'b0;
    endtask

    task automatic do_pop(input logic [7:0] e);
        pop = 1'b1;
        exp_q.push_back(e);
        cyc();
        pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rs1 = '0; rs2 = '0; ws = '0; wd = '0; regwrite = 1'b0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_pc = '0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;

        // 1: reset state
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i);
            rs2 = 3'(7 - i);
            #1;
            chk($sformatf("reset_rd1[%0d]", i), rd1, 32'h0);
            chk($sformatf("reset_rd2[%0d]", 7 - i), rd2, 32'h0);
        end
        chk("reset_empty", {31'b0, stack_empty}, 32'h1);
        chk("reset_full", {31'b0, stack_full}, 32'h0);
        chk("reset_pop_valid", {31'b0, pop_valid}, 32'h0);
        chk("reset_flags", {30'b0, stack_ovf, stack_unf}, 32'h0);

        // 2: write, same-cycle read, next-cycle read
        cyc();
        regwrite = 1'b1; ws = 3'd3; wd = 32'hDEADBEEF; rs1 = 3'd3; rs2 = 3'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr_same_cycle_rd1", rd1, 32'hDEADBEEF);
`else
        chk("wr_same_cycle_rd1", rd1, 32'h0);
`endif
        chk("wr_other_rd2", rd2, 32'h0);
        cyc();
        ws = 3'd5; wd = 32'h12345678; rs2 = 3'd5;
        #1;
        chk("wr_next_cycle_rd1", rd1, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
        chk("wr_same_cycle_rd2", rd2, 32'h12345678);
`else
        chk("wr_same_cycle_rd2", rd2, 32'h0);
`endif
        cyc();
        regwrite = 1'b0;
        #1;
        chk("wr_next_cycle_rd2", rd2, 32'h12345678);
        chk("wr_keep_rd1", rd1, 32'hDEADBEEF);

        // 3: push three, pop three
        do_push(8'h10);
        do_push(8'h20);
        do_push(8'h30);
        #1;
        chk("three_not_empty", {31'b0, stack_empty}, 32'h0);
        do_pop(8'h31);
        do_pop(8'h21);
        do_pop(8'h11);
        cyc();
        chk("three_drained_empty", {31'b0, stack_empty}, 32'h1);
        chk("three_queue_drained", exp_q.size(), 32'd0);

        // 4: fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            do_push(8'(8'h80 + i));
        end
        #1;
        chk("fill_full", {31'b0, stack_full}, 32'h1);
        chk("fill_no_ovf", {31'b0, stack_ovf}, 32'h0);
        do_push(8'hA0);
        #1;
        chk("ovf_set", {31'b0, stack_ovf}, 32'h1);
        chk("ovf_still_full", {31'b0, stack_full}, 32'h1);
        do_pop(8'h90);
        #1;
        chk("after_pop_not_full", {31'b0, stack_full}, 32'h0);
        for (int i = 14; i >= 0; i--) begin
            do_pop(8'(8'h81 + i));
        end
        #1;
        chk("drain_empty", {31'b0, stack_empty}, 32'h1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        #1;
        chk("ovf_cleared", {31'b0, stack_ovf}, 32'h0);

        // 5: underflow, clear, clear-vs-new-error, swap
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("unf_set", {31'b0, stack_unf}, 32'h1);
        chk("unf_no_valid", {31'b0, pop_valid}, 32'h0);
        chk("unf_pop_pc_hold", {24'b0, pop_pc}, 32'h81);
        pop = 1'b1; clr_err = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("unf_new_error_wins", {31'b0, stack_unf}, 32'h1);
        cyc();
        clr_err = 1'b0;
        #1;
        chk("unf_cleared", {31'b0, stack_unf}, 32'h0);
        do_push(8'h40);
        push = 1'b1; push_pc = 8'h50; pop = 1'b1;
        exp_q.push_back(8'h41);
        cyc();
        push = 1'b0; pop = 1'b0;
        #1;
        chk("swap_not_empty", {31'b0, stack_empty}, 32'h0);
        do_pop(8'h51);
        #1;
        chk("swap_sp_unchanged", {31'b0, stack_empty}, 32'h1);
        push = 1'b1; push_pc = 8'h60; pop = 1'b1;
        cyc();
        push = 1'b0; pop = 1'b0;
        #1;
        chk("swap_empty_unf", {31'b0, stack_unf}, 32'h1);
        chk("swap_empty_pushed", {31'b0, stack_empty}, 32'h0);
        do_pop(8'h61);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;

        // 6: wraparound, then reset while a pop is pending
        do_push(8'hFF);
        do_pop(8'h00);
        do_push(8'h33);
        do_pop(8'h34);
        do_push(8'h22);
        #1;
        chk("pre_reset_pop_pc", {24'b0, pop_pc}, 32'h34);
        pop = 1'b1; rs1 = 3'd3;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_pop_pc", {24'b0, pop_pc}, 32'h0);
        chk("rst_pop_valid", {31'b0, pop_valid}, 32'h0);
        chk("rst_empty", {31'b0, stack_empty}, 32'h1);
        chk("rst_rd1", rd1, 32'h0);
        pop = 1'b0;
        cyc();
        reset = 1'b0;
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        #1;
        chk("post_rst_unf", {31'b0, stack_unf}, 32'h1);
        cyc();
        cyc();
        chk("final_queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

endmodule
